// File: rtl/serial_frame_tx_if.sv
// Parallel-load / serial-out handshake bundle for serial_frame_tx.
// The master drives the word and the load strobe; the slave returns the line and status.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] Din;
    logic              Load;
    logic              Tx;
    logic              Busy;
    logic              Done;

    modport master (
        output Din,
        output Load,
        input  Tx,
        input  Busy,
        input  Done
    );

    modport slave (
        input  Din,
        input  Load,
        output Tx,
        output Busy,
        output Done
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit (0), DATA_W bits LSB first, stop bit (1).
// Each bit is held for CLKS_PER_BIT clocks; every output comes straight from a flop.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             Reset,
    serial_frame_tx_if.slave bus
);
    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic [DATA_W-1:0]   shift_nxt;
    logic                tick_last;
    logic                tx_q;
    logic                busy_q;
    logic                done_q;

    assign tick_last = (tick_cnt == TICK_LAST);
    assign shift_nxt = shift_reg >> 1;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.Load) begin
                        shift_reg <= bus.Din;
                        tick_cnt  <= '0;
                        bit_cnt   <= '0;
                        state     <= START;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                START: begin
                    if (tick_last) begin
                        tick_cnt <= '0;
                        state    <= DATA;
                        tx_q     <= shift_reg[0];
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (tick_last) begin
                        tick_cnt  <= '0;
                        shift_reg <= shift_nxt;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            // Present the next bit on the same edge the register shifts.
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_q    <= shift_nxt[0];
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (tick_last) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                        tx_q     <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Tx   = tx_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a CLKS_PER_BIT=4 and a CLKS_PER_BIT=1 instance share stimulus;
// a frame-position model checks both every cycle, plus table vectors and hand-written sequences.
module tb_serial_frame_tx;
    localparam int DW = 8;
    localparam int F4 = (DW + 2) * 4;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] din_s;
    logic       load_s;

    always #5 clk = ~clk;

    serial_frame_tx_if #(.DATA_W(DW)) bus4 ();
    serial_frame_tx_if #(.DATA_W(DW)) bus1 ();

    assign bus4.Din  = din_s;
    assign bus4.Load = load_s;
    assign bus1.Din  = din_s;
    assign bus1.Load = load_s;

    serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(4)) dut4 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus4.slave)
    );

    serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus1.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Reference model: a frame is (DW+2)*cpb cycles long; the line level is
    // simply the symbol at position pos/cpb of {start, data LSB first, stop}.
    int         cpb_m [2] = '{4, 1};
    int         m_pos [2];
    bit         m_busy[2];
    bit         m_done[2];
    logic [7:0] m_word[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pos[d] = 0; m_busy[d] = 1'b0; m_done[d] = 1'b0; m_word[d] = '0;
        end
    endtask

    task automatic model_update();
        for (int d = 0; d < 2; d++) begin
            m_done[d] = 1'b0;
            if (Reset) begin
                m_pos[d] = 0; m_busy[d] = 1'b0; m_word[d] = '0;
            end else if (m_busy[d]) begin
                m_pos[d]++;
                if (m_pos[d] == (DW + 2) * cpb_m[d]) begin
                    m_busy[d] = 1'b0;
                    m_done[d] = 1'b1;
                end
            end else if (load_s) begin
                m_busy[d] = 1'b1;
                m_pos[d]  = 0;
                m_word[d] = din_s;
            end
        end
    endtask

    function automatic logic exp_tx(input int d);
        int k;
        if (!m_busy[d]) return 1'b1;
        k = m_pos[d] / cpb_m[d];
        if (k == 0) return 1'b0;
        if (k == DW + 1) return 1'b1;
        return m_word[d][k-1];
    endfunction

    task automatic check_model();
        check1("model_tx4",   bus4.Tx,   exp_tx(0));
        check1("model_busy4", bus4.Busy, m_busy[0]);
        check1("model_done4", bus4.Done, m_done[0]);
        check1("model_tx1",   bus1.Tx,   exp_tx(1));
        check1("model_busy1", bus1.Busy, m_busy[1]);
        check1("model_done1", bus1.Done, m_done[1]);
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus4.Busy || bus1.Busy) && n < 200) begin
            step();
            n++;
        end
        check1("idle_wait", bus4.Busy | bus1.Busy, 1'b0);
    endtask

    // Serial symbols written left-to-right in line order: bit [9-j] is symbol j.
    typedef struct packed {
        logic [7:0] din;
        logic [9:0] bits;
        logic       sel1;
    } vec_t;

    vec_t       tbl[7];
    logic [9:0] cap_bits;
    int         cap_done;
    int         cap_at;

    // Sends din on the CPB=4 instance, sampling mid-bit; optional ignored load at ign_at.
    task automatic capture4(input logic [7:0] din, input int ign_at);
        cap_bits = '0; cap_done = 0; cap_at = -1;
        din_s = din; load_s = 1'b1;
        step();
        load_s = 1'b0; din_s = 8'($urandom);
        for (int k = 0; k <= F4 + 4; k++) begin
            if ((k % 4) == 2 && (k / 4) < 10) cap_bits[9 - k/4] = bus4.Tx;
            if (bus4.Done) begin cap_done++; cap_at = k; end
            if (k == ign_at) begin din_s = 8'hFF; load_s = 1'b1; end
            else if (k == ign_at + 1) load_s = 1'b0;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] f1, f2;
        int d1_at, d2_at, n_done;
        logic gap_tx, start_tx;

        tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
        tbl[1] = '{8'h3C, 10'b0001111001, 1'b0};
        tbl[2] = '{8'h00, 10'b0000000001, 1'b0};
        tbl[3] = '{8'hFF, 10'b0111111111, 1'b0};
        tbl[4] = '{8'h01, 10'b0100000001, 1'b0};
        tbl[5] = '{8'h80, 10'b0000000011, 1'b0};
        tbl[6] = '{8'h55, 10'b0101010101, 1'b1};

        Reset = 1'b1; din_s = '0; load_s = 1'b0;
        model_reset();
        #1;
        check1("rst_tx4", bus4.Tx, 1'b1);
        check1("rst_busy4", bus4.Busy, 1'b0);
        check1("rst_done4", bus4.Done, 1'b0);
        check1("rst_tx1", bus1.Tx, 1'b1);
        repeat (3) step();
        Reset = 1'b0;
        repeat (2) step();

        // Table vectors: per-cycle line level, Busy window and Done position.
        for (int i = 0; i < 7; i++) begin
            int cpb, f;
            logic tx, busy, done;
            wait_idle();
            cpb = tbl[i].sel1 ? 1 : 4;
            f   = 10 * cpb;
            din_s = tbl[i].din; load_s = 1'b1;
            step();
            load_s = 1'b0; din_s = 8'($urandom);
            for (int k = 0; k <= f; k++) begin
                tx   = tbl[i].sel1 ? bus1.Tx   : bus4.Tx;
                busy = tbl[i].sel1 ? bus1.Busy : bus4.Busy;
                done = tbl[i].sel1 ? bus1.Done : bus4.Done;
                check1($sformatf("tbl%0d_tx_k%0d", i, k), tx, (k < f) ? tbl[i].bits[9 - k/cpb] : 1'b1);
                check1($sformatf("tbl%0d_busy_k%0d", i, k), busy, k < f);
                check1($sformatf("tbl%0d_done_k%0d", i, k), done, k == f);
                if (k < f) step();
            end
        end

        // Load during a frame is dropped.
        wait_idle();
        capture4(8'h3C, 12);
        checkn("ignored_load_bits", int'(cap_bits), int'(10'b0001111001));
        checkn("ignored_load_done_count", cap_done, 1);
        checkn("ignored_load_done_at", cap_at, F4);
        check1("ignored_load_no_second_frame", bus4.Busy, 1'b0);

        // Load held high: back-to-back frames, Din swapped after the first accept.
        wait_idle();
        f1 = '0; f2 = '0; d1_at = -1; d2_at = -1; n_done = 0; gap_tx = 1'b0; start_tx = 1'b1;
        din_s = 8'h01; load_s = 1'b1;
        step();
        din_s = 8'h80;
        for (int k = 0; k <= 86; k++) begin
            if (k < F4 && (k % 4) == 2) f1[9 - k/4] = bus4.Tx;
            if (k >= F4 + 1 && k < 2*F4 + 1 && ((k - F4 - 1) % 4) == 2) f2[9 - (k - F4 - 1)/4] = bus4.Tx;
            if (k == F4) gap_tx = bus4.Tx;
            if (k == F4 + 1) start_tx = bus4.Tx;
            if (bus4.Done) begin
                n_done++;
                if (d1_at < 0) d1_at = k; else if (d2_at < 0) d2_at = k;
            end
            if (k == 2*F4 + 1) load_s = 1'b0;
            step();
        end
        checkn("b2b_frame1_bits", int'(f1), int'(10'b0100000001));
        checkn("b2b_frame2_bits", int'(f2), int'(10'b0000000011));
        check1("b2b_idle_gap_high", gap_tx, 1'b1);
        check1("b2b_second_start_low", start_tx, 1'b0);
        checkn("b2b_done_count", n_done, 2);
        checkn("b2b_first_done_at", d1_at, F4);
        checkn("b2b_done_spacing", d2_at - d1_at, F4 + 1);

        // Asynchronous reset during data bit 3 of 8'h00.
        wait_idle();
        din_s = 8'h00; load_s = 1'b1;
        step();
        load_s = 1'b0;
        repeat (17) step();
        check1("abort_pre_tx_low", bus4.Tx, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        check1("abort_async_tx4", bus4.Tx, 1'b1);
        check1("abort_async_busy4", bus4.Busy, 1'b0);
        check1("abort_async_done4", bus4.Done, 1'b0);
        model_reset();
        repeat (2) step();
        Reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < 45; k++) begin
            if (bus4.Done) n_done++;
            step();
        end
        checkn("abort_no_done", n_done, 0);
        capture4(8'hFF, -1);
        checkn("after_abort_bits", int'(cap_bits), int'(10'b0111111111));
        checkn("after_abort_done_count", cap_done, 1);
        checkn("after_abort_done_at", cap_at, F4);

        // Random traffic against the model, including bursts of held Load.
        wait_idle();
        for (int i = 0; i < 3000; i++) begin
            din_s = 8'($urandom);
            if ((i / 500) % 2 == 1) load_s = ($urandom_range(0, 3) != 0);
            else load_s = ($urandom_range(0, 15) == 0);
            step();
        end
        load_s = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
